// File: rtl/gray_counter_param.sv
// gray_counter_param: up/down counter holding registered binary and Gray forms, with Gray load, optional saturation and terminal-count flag.
module gray_counter_param #(
  parameter int WIDTH = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary,
  output logic             term
);
  logic [WIDTH-1:0] load_bin, nxt;
  logic at_end;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_dec
      assign load_bin[i] = ^load_gray[WIDTH-1:i];
    end
  endgenerate
  always_comb begin
    at_end = up ? &binary : ~|binary;
    nxt = (at_end && SATURATE) ? binary : up ? binary + WIDTH'(1) : binary - WIDTH'(1);
  end
  // Gray is re-encoded from the next binary value so both registers stay consistent
  always_ff @(posedge clk) begin
    if (rst) begin
      binary <= '0;
      gray <= '0;
      term <= 1'b0;
    end else if (load) begin
      binary <= load_bin;
      gray <= load_gray;
      term <= 1'b0;
    end else if (en) begin
      binary <= nxt;
      gray <= nxt ^ (nxt >> 1);
      term <= at_end;
    end else begin
      term <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gray_counter_param.sv
// tb_gray_counter_param: directed and randomized checks of four counter variants against an arithmetic reference model.
module tb_gray_counter_param;
  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [7:0] lg = '0;
  logic [3:0] g0, b0, g1, b1;
  logic [1:0] g2, b2;
  logic [7:0] g3, b3;
  logic t0, t1, t2, t3;
  int vectors = 0, miscompares = 0;
  int unsigned mb[4];
  bit mt[4];
  int wd[4] = '{4, 4, 2, 8};
  bit st[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] up_seq[16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_gray(lg[3:0]), .gray(g0), .binary(b0), .term(t0));
  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1)) u1 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_gray(lg[3:0]), .gray(g1), .binary(b1), .term(t1));
  gray_counter_param #(.WIDTH(2), .SATURATE(1'b0)) u2 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_gray(lg[1:0]), .gray(g2), .binary(b2), .term(t2));
  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0)) u3 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_gray(lg), .gray(g3), .binary(b3), .term(t3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned g2b(input int unsigned g, input int w);
    int unsigned b = 0;
    for (int k = 0; k < w; k++) b ^= g >> k;
    return b;
  endfunction

  function automatic int unsigned obs_g(input int j);
    return j == 0 ? 32'(g0) : j == 1 ? 32'(g1) : j == 2 ? 32'(g2) : 32'(g3);
  endfunction

  function automatic int unsigned obs_b(input int j);
    return j == 0 ? 32'(b0) : j == 1 ? 32'(b1) : j == 2 ? 32'(b2) : 32'(b3);
  endfunction

  function automatic bit obs_t(input int j);
    return j == 0 ? t0 : j == 1 ? t1 : j == 2 ? t2 : t3;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic u, input logic l, input logic [7:0] g);
    rst = r; en = e; up = u; load = l; lg = g;
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      int unsigned m = (32'd1 << wd[j]) - 1;
      if (r) begin
        mb[j] = 0; mt[j] = 0;
      end else if (l) begin
        mb[j] = g2b(32'(g) & m, wd[j]); mt[j] = 0;
      end else if (e) begin
        if ((u && mb[j] == m) || (!u && mb[j] == 0)) begin
          mt[j] = 1;
          if (!st[j]) mb[j] = u ? 0 : m;
        end else begin
          mt[j] = 0;
          mb[j] = u ? mb[j] + 1 : mb[j] - 1;
        end
      end else mt[j] = 0;
    end
    #1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("model_bin%0d", j), obs_b(j), mb[j]);
      check($sformatf("model_gray%0d", j), obs_g(j), mb[j] ^ (mb[j] >> 1));
      check($sformatf("model_term%0d", j), 32'(obs_t(j)), 32'(mt[j]));
      check($sformatf("decode%0d", j), obs_b(j), g2b(obs_g(j), wd[j]));
    end
  endtask

  initial begin
    logic [3:0] prev;
    int n2, n3;
    cycle(1, 0, 0, 0, 0);
    check("reset_gray", 32'(g0), 0);
    check("reset_term", 32'(t0), 0);
    prev = g0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 1, 0, 0);
      check("up_seq", 32'(g0), 32'(up_seq[i]));
      check("up_term", 32'(t0), 32'(i == 15));
      check("up_onebit", $countones(prev ^ g0), 1);
      prev = g0;
    end
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("down_wrap_bin", 32'(b0), 4'b1111);
    check("down_wrap_gray", 32'(g0), 4'b1000);
    check("down_wrap_term", 32'(t0), 1);
    cycle(0, 1, 0, 0, 0);
    check("down2_bin", 32'(b0), 4'b1110);
    check("down2_gray", 32'(g0), 4'b1001);
    check("down2_term", 32'(t0), 0);
    cycle(0, 0, 0, 1, 8'h0D);
    check("load_bin", 32'(b0), 4'b1001);
    check("load_gray", 32'(g0), 4'b1101);
    cycle(0, 1, 1, 0, 0);
    check("load_up_bin", 32'(b0), 4'b1010);
    check("load_up_gray", 32'(g0), 4'b1111);
    cycle(0, 1, 1, 1, 8'h0D);
    check("load_wins", 32'(g0), 4'b1101);
    cycle(0, 0, 0, 1, 8'h08);
    check("sat_load_bin", 32'(b1), 4'b1111);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 0, 0);
      check("sat_gray", 32'(g1), 4'b1000);
      check("sat_term", 32'(t1), 1);
    end
    cycle(0, 1, 0, 0, 0);
    check("sat_down_gray", 32'(g1), 4'b1001);
    check("sat_down_term", 32'(t1), 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);
    check("mid_gray", 32'(g0), 4'b0110);
    cycle(1, 1, 1, 0, 0);
    check("mid_rst_gray", 32'(g0), 0);
    check("mid_rst_bin", 32'(b0), 0);
    check("mid_rst_term", 32'(t0), 0);
    cycle(0, 1, 1, 0, 0);
    check("resume_gray", 32'(g0), 4'b0001);
    cycle(1, 0, 0, 0, 0);
    n2 = 0; n3 = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(0, 1, 1, 0, 0);
      n2 += int'(t2); n3 += int'(t3);
    end
    check("sweep8_up_terms", n3, 1);
    check("sweep2_up_terms", n2, 64);
    n2 = 0; n3 = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(0, 1, 0, 0, 0);
      n2 += int'(t2); n3 += int'(t3);
    end
    check("sweep8_down_terms", n3, 1);
    check("sweep2_down_terms", n2, 64);
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(99) == 0, $urandom_range(9) < 7, 1'($urandom), $urandom_range(19) == 0, 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
